// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder and its RAM.
package dmem_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Word seen after a byte-masked store: masked lanes from new_word, the rest from old_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  mask);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (mask[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port byte-enabled RAM, synchronous read, write-first. No reset: contents persist.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [3:0]            wmask,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0] mem [DEPTH];

    // Byte-lane write and write-first read when enabled; rdata holds otherwise.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (wmask[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
            rdata <= merge_bytes(mem[addr], wdata, wmask);
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, optional wait states, word response.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready for a request (req_ready=1)
// WAIT   | stalling WAIT_CYCLES cycles after acceptance
// ACCESS | one cycle with the RAM enabled (unless out of range)
// RESP   | response presented, held until rsp_ready
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic [29:0]     word_addr_q;
    logic [31:0]     wdata_q;
    logic [3:0]      wmask_q;
    logic            err_q;
    logic            accept;
    logic            range_err;
    logic            ram_en;
    logic [31:0]     ram_rdata;
    logic            addr_lsb_unused;

    // Byte offset within the word carries no meaning here.
    assign addr_lsb_unused = ^req_addr[1:0];

    assign accept    = req_valid && (state == IDLE);
    assign range_err = (word_addr_q >> ADDR_WIDTH) != 30'd0;

    // The reset term keeps a store whose ACCESS edge meets reset from landing in the RAM.
    assign ram_en = (state == ACCESS) && !range_err && reset;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES > 0) state_nx = WAIT;
                    else                 state_nx = ACCESS;
                end
            end
            WAIT:    if (cnt <= CW'(1)) state_nx = ACCESS;
            ACCESS:  state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Wait-state down-counter: loaded on acceptance, saturates at zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CW'(WAIT_CYCLES);
        end else if ((state == WAIT) && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Request capture on the handshake.
    always_ff @(posedge clk) begin
        if (!reset) begin
            word_addr_q <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
        end else if (accept) begin
            word_addr_q <= req_addr[31:2];
            wdata_q     <= req_wdata;
            wmask_q     <= req_wmask;
        end
    end

    // Error flag for the pending response; cleared when the response is taken.
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (state == ACCESS) begin
            err_q <= range_err;
        end else if ((state == RESP) && rsp_ready) begin
            err_q <= 1'b0;
        end
    end

    dmem_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .wmask(wmask_q),
        .addr (word_addr_q[ADDR_WIDTH-1:0]),
        .wdata(wdata_q),
        .rdata(ram_rdata)
    );

    // Handshake and response outputs; RAM output is stable through RESP since the RAM is idle.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        if (state == IDLE) req_ready = 1'b1;
        if (state == RESP) begin
            rsp_valid = 1'b1;
            rsp_err   = err_q;
            if (!err_q) rsp_rdata = ram_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 without wait states, instance 1 with three.
module tb_dmem_responder;
    import dmem_pkg::*;

    typedef struct {
        int          k;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset     [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_wmask [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int checks = 0;
    int errors = 0;
    int rsp_cnt0 = 0;
    rsp_t q0[$];
    rsp_t q1[$];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) dut1 (
        .clk(clk), .reset(reset[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int k, input logic [31:0] rdata, input logic err);
        rsp_t e;
        e.rdata = rdata;
        e.err   = err;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Scoreboard side: compare each response as its handshake is about to happen.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid[0] && rsp_ready[0]) begin
                rsp_cnt0++;
                if (q0.size() == 0) chk("dut0 unexpected response", 32'd1, 32'd0);
                else begin
                    e = q0.pop_front();
                    chk("dut0 rsp_rdata", rsp_rdata[0], e.rdata);
                    chk("dut0 rsp_err", {31'd0, rsp_err[0]}, {31'd0, e.err});
                end
            end
            if (rsp_valid[1] && rsp_ready[1]) begin
                if (q1.size() == 0) chk("dut1 unexpected response", 32'd1, 32'd0);
                else begin
                    e = q1.pop_front();
                    chk("dut1 rsp_rdata", rsp_rdata[1], e.rdata);
                    chk("dut1 rsp_err", {31'd0, rsp_err[1]}, {31'd0, e.err});
                end
            end
        end
    end

    // Present a request and return at #1 after the accepting edge.
    task automatic send(input int k, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wmask);
        bit done = 0;
        req_valid[k] = 1'b1;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        req_wmask[k] = wmask;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (req_ready[k]) begin
                @(posedge clk);
                #1;
                req_valid[k] = 1'b0;
                done = 1;
            end
        end
        if (!done) begin
            chk("accept timeout", 32'd0, 32'd1);
            req_valid[k] = 1'b0;
        end
    endtask

    task automatic drain(input int k);
        bit done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(posedge clk);
            #1;
            if ((k == 0 ? q0.size() : q1.size()) == 0) done = 1;
        end
        if (!done) chk("response timeout", 32'd0, 32'd1);
    endtask

    task automatic do_req(input int k, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wmask, input logic [31:0] exp_rdata,
                          input logic exp_err);
        push_exp(k, exp_rdata, exp_err);
        send(k, addr, wdata, wmask);
        drain(k);
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        vec_t        vecs[$];
        logic [31:0] mdl [4];
        logic [31:0] wd;
        logic [3:0]  wm;
        int          idx;
        int          acc;
        int          start_cnt;
        logic [31:0] b2b_addr  [3];
        logic [31:0] b2b_wdata [3];
        logic [3:0]  b2b_wmask [3];

        vecs.push_back('{0, 32'h100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{0, 32'h100, 32'h0,        4'b0000, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{0, 32'h40,  32'h11223344, 4'b1111, 32'h11223344, 1'b0});
        vecs.push_back('{0, 32'h42,  32'h00AB0000, 4'b0100, 32'h11AB3344, 1'b0});
        vecs.push_back('{0, 32'h40,  32'h0,        4'b0000, 32'h11AB3344, 1'b0});
        vecs.push_back('{0, 32'h43,  32'hFFFFFFFF, 4'b0000, 32'h11AB3344, 1'b0});
        vecs.push_back('{0, 32'h0,   32'h01020304, 4'b1111, 32'h01020304, 1'b0});
        vecs.push_back('{0, 32'h1000, 32'hFFFFFFFF, 4'b1111, 32'h0,       1'b1});
        vecs.push_back('{0, 32'h0,   32'h0,        4'b0000, 32'h01020304, 1'b0});
        vecs.push_back('{0, 32'hFFC, 32'h12345678, 4'b1111, 32'h12345678, 1'b0});
        vecs.push_back('{0, 32'hFFC, 32'hA5A5A5A5, 4'b1001, 32'hA53456A5, 1'b0});
        vecs.push_back('{0, 32'hFFC, 32'h0,        4'b0000, 32'hA53456A5, 1'b0});
        vecs.push_back('{0, 32'h80000000, 32'h0,   4'b0000, 32'h0,        1'b1});
        vecs.push_back('{1, 32'h80,  32'h55AA55AA, 4'b1111, 32'h55AA55AA, 1'b0});
        vecs.push_back('{1, 32'h80,  32'h0,        4'b0000, 32'h55AA55AA, 1'b0});

        for (int k = 0; k < 2; k++) begin
            reset[k]     = 1'b0;
            req_valid[k] = 1'b0;
            req_addr[k]  = '0;
            req_wdata[k] = '0;
            req_wmask[k] = '0;
            rsp_ready[k] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("reset req_ready", {31'd0, req_ready[k]}, 32'd1);
            chk("reset rsp_valid", {31'd0, rsp_valid[k]}, 32'd0);
            chk("reset rsp_rdata", rsp_rdata[k], 32'd0);
            chk("reset rsp_err",   {31'd0, rsp_err[k]},   32'd0);
            reset[k] = 1'b1;
        end
        @(posedge clk);
        #1;

        foreach (vecs[i])
            do_req(vecs[i].k, vecs[i].addr, vecs[i].wdata, vecs[i].wmask,
                   vecs[i].exp_rdata, vecs[i].exp_err);

        // Wait-state timing and response hold with three wait cycles.
        rsp_ready[1] = 1'b0;
        push_exp(1, 32'hCAFEF00D, 1'b0);
        send(1, 32'h20, 32'hCAFEF00D, 4'b1111);
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            chk($sformatf("timing req_ready c%0d", c), {31'd0, req_ready[1]}, 32'd0);
            chk($sformatf("timing rsp_valid c%0d", c), {31'd0, rsp_valid[1]},
                (c >= 5) ? 32'd1 : 32'd0);
            if (c >= 5) chk($sformatf("hold rsp_rdata c%0d", c), rsp_rdata[1], 32'hCAFEF00D);
        end
        @(posedge clk);
        #1;
        rsp_ready[1] = 1'b1;
        chk("rsp handshake cycle req_ready", {31'd0, req_ready[1]}, 32'd0);
        @(posedge clk);
        #1;
        chk("after rsp req_ready", {31'd0, req_ready[1]}, 32'd1);
        chk("after rsp rsp_valid", {31'd0, rsp_valid[1]}, 32'd0);
        chk("after rsp rsp_rdata", rsp_rdata[1], 32'd0);
        chk("queue1 empty", q1.size(), 32'd0);

        // Reset during WAIT of a store: nothing committed, no response.
        send(1, 32'h80, 32'hFFFFFFFF, 4'b1111);
        @(posedge clk);
        #1;
        reset[1] = 1'b0;
        @(posedge clk);
        #1;
        reset[1] = 1'b1;
        chk("wait-reset req_ready", {31'd0, req_ready[1]}, 32'd1);
        for (int c = 0; c < 6; c++) begin
            chk("wait-reset rsp_valid", {31'd0, rsp_valid[1]}, 32'd0);
            @(posedge clk);
            #1;
        end
        do_req(1, 32'h80, 32'h0, 4'b0000, 32'h55AA55AA, 1'b0);

        // Reset on the ACCESS edge of a store: the store must not land.
        send(0, 32'h100, 32'h00000000, 4'b1111);
        reset[0] = 1'b0;
        @(posedge clk);
        #1;
        reset[0] = 1'b1;
        chk("access-reset req_ready", {31'd0, req_ready[0]}, 32'd1);
        chk("access-reset rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
        @(posedge clk);
        #1;
        chk("access-reset rsp_valid later", {31'd0, rsp_valid[0]}, 32'd0);
        do_req(0, 32'h100, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0);

        // Back-to-back: req_valid held high across three requests.
        b2b_addr  = '{32'h200, 32'h200, 32'h201};
        b2b_wdata = '{32'hAABBCCDD, 32'h0, 32'h00001100};
        b2b_wmask = '{4'b1111, 4'b0000, 4'b0010};
        push_exp(0, 32'hAABBCCDD, 1'b0);
        push_exp(0, 32'hAABBCCDD, 1'b0);
        push_exp(0, 32'hAABB11DD, 1'b0);
        start_cnt = rsp_cnt0;
        acc = 0;
        req_valid[0] = 1'b1;
        req_addr[0]  = b2b_addr[0];
        req_wdata[0] = b2b_wdata[0];
        req_wmask[0] = b2b_wmask[0];
        for (int i = 0; i < 100 && acc < 3; i++) begin
            @(negedge clk);
            if (req_ready[0]) begin
                chk("b2b accept only when idle", {31'd0, rsp_valid[0]}, 32'd0);
                acc++;
                @(posedge clk);
                #1;
                if (acc < 3) begin
                    req_addr[0]  = b2b_addr[acc];
                    req_wdata[0] = b2b_wdata[acc];
                    req_wmask[0] = b2b_wmask[acc];
                end else begin
                    req_valid[0] = 1'b0;
                end
            end
        end
        req_valid[0] = 1'b0;
        chk("b2b accepts", acc, 32'd3);
        drain(0);
        chk("b2b responses", rsp_cnt0 - start_cnt, 32'd3);

        // Random masked stores and loads against a small word model.
        for (int i = 0; i < 4; i++) begin
            mdl[i] = $urandom;
            do_req(1, 32'h300 + 32'(4 * i), mdl[i], 4'b1111, mdl[i], 1'b0);
        end
        for (int i = 0; i < 12; i++) begin
            idx = $urandom_range(0, 3);
            wd  = $urandom;
            wm  = 4'($urandom_range(0, 15));
            if (wm != 4'b0000) mdl[idx] = merge_bytes(mdl[idx], wd, wm);
            do_req(1, 32'h300 + 32'(4 * idx) + 32'($urandom_range(0, 3)), wd, wm,
                   mdl[idx], 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the RISC-V core's load/store port: the slave end of the core's memory interface, which issues byte address, lane-placed write data and 4-bit write mask. The block accepts one request at a time over a valid/ready handshake and applies byte-lane writes or performs word reads on an internal RAM after configurable wait states. It returns a word response with an error flag. The core does all lane placement and sign extension; this block only honours the mask.

Parameters:
ADDR_WIDTH, 10, word-address bits; RAM depth = 2**ADDR_WIDTH words of 32 bits
WAIT_CYCLES, 0, extra stall cycles inserted between request acceptance and the RAM access (0..15)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous active-low reset: reset==0 at a rising edge resets the block
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_addr  input  32  byte address; bits [1:0] ignored
req_wdata  input  32  write data, already lane-placed
req_wmask  input  4  byte write enables; nonzero = store, 4'b0000 = load
rsp_valid  output  1  response present
rsp_ready  input  1  requester accepts response
rsp_rdata  output  32  read word, or post-write merged word for stores; 0 on error
rsp_err  output  1  address out of range

Behaviour:
- Clock is clk; reset is synchronous, active-low. At reset: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. RAM contents are not reset.
- Acceptance: req_valid && req_ready at a rising edge latches addr, wdata and wmask. req_ready is 1 only in IDLE. Inputs outside the handshake are don't-care.
- FSM: IDLE -> WAIT on accept when WAIT_CYCLES>0, else IDLE -> ACCESS. WAIT counts WAIT_CYCLES cycles, then -> ACCESS. ACCESS lasts 1 cycle, then -> RESP. RESP holds until rsp_ready, then -> IDLE.
- Timing, with the handshake in cycle 0: WAIT occupies cycles 1..WAIT_CYCLES. ACCESS is cycle WAIT_CYCLES+1. rsp_valid is first high in cycle WAIT_CYCLES+2.
- Throughput: at most 1 request per WAIT_CYCLES+3 cycles. There is no overlap, and req_ready is 0 during the cycle in which the response handshakes.
- Range check: the request is out of range when latched addr[31:ADDR_WIDTH+2] != 0. In that case the RAM is not enabled, rsp_err=1 and rsp_rdata=0. The response timing is unchanged.
- Store in ACCESS: byte lane i is written only where wmask[i]=1; other lanes are preserved. rsp_rdata = the full merged word (write-first).
- Load in ACCESS: rsp_rdata = the stored word at addr[ADDR_WIDTH+1:2].
- In RESP, rsp_rdata and rsp_err are stable while rsp_valid=1 && !rsp_ready. Both are cleared to 0 on leaving RESP.
- A read immediately following a write to the same word returns the written data.
- Reset mid-operation (WAIT or ACCESS before the edge): the FSM returns to IDLE, no response is issued, and a store whose ACCESS edge coincides with the reset edge is not committed. RAM retains all previously committed writes.
- Counter width is max(1, $clog2(WAIT_CYCLES+1)); the counter saturates and never wraps.

Decomposition:
- Package dmem_pkg holds: the state enum (IDLE, WAIT, ACCESS, RESP); constant WORD_BYTES=4; and a function merge_bytes(old, new, mask) for the post-write word, shared with the bench model.
- One sub-module, dmem_ram: single-port, byte-enabled, synchronous-read, write-first RAM of depth 2**ADDR_WIDTH. It has no reset. dmem_responder contains the FSM, counter, range check and response registers.

Test Plan:
- Reset, then a store at addr 0x100 with wdata 0xDEADBEEF, mask 4'b1111, followed by a load at 0x100, with WAIT_CYCLES=0 -> store response rsp_rdata=0xDEADBEEF in cycle 2; load response 0xDEADBEEF; rsp_err=0 for both.
- Byte store: start from 0x11223344 at 0x40, then a store at addr 0x42 with wdata 0x00AB0000, mask 4'b0100 -> rsp_rdata=0x11AB3344; a later load at 0x40 returns 0x11AB3344.
- WAIT_CYCLES=3, handshake in cycle 0 -> req_ready=0 in cycles 1..5, rsp_valid first high in cycle 5; hold rsp_ready=0 for 4 cycles -> rsp_rdata stable; req_ready=1 the cycle after the rsp handshake.
- Out-of-range store at addr 0x00001000 (ADDR_WIDTH=10) with mask 4'b1111 -> rsp_err=1, rsp_rdata=0; a later load at 0x0 returns its prior contents unchanged.
- Reset asserted (reset=0) during WAIT of a store to 0x80 with mask 4'b1111 -> no rsp_valid, req_ready=1 after reset; a load at 0x80 returns the old word.
- Back-to-back: req_valid held high with 3 requests queued -> each is accepted only in IDLE, responses come in order with no lost or duplicated handshakes.
